// File: rtl/turn_scheduler.sv
// Two-player turn arbiter for the artillery game.
// Passes keyboard codes to the player whose turn it is and runs each turn
// through aim window, bomb flight, settle delay and hand-over.
// All outputs come straight from registers; nothing is combinational from inputs.
module turn_scheduler #(
   parameter int         TURN_FRAMES    = 600,
   parameter int         FLIGHT_TIMEOUT = 480,
   parameter int         SETTLE_FRAMES  = 60,
   parameter logic [7:0] START_KEY      = 8'h28
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   input  logic [1:0] bomb_active,
   output logic [7:0] key_p0,
   output logic [7:0] key_p1,
   output logic       active,
   output logic [2:0] state,
   output logic [9:0] timer,
   output logic [7:0] turn_count
);

   // Flight counter only has to reach FLIGHT_TIMEOUT-1.
   localparam int FW = (FLIGHT_TIMEOUT > 2) ? $clog2(FLIGHT_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      AIM    = 3'd1,
      FLIGHT = 3'd2,
      SETTLE = 3'd3,
      SWITCH = 3'd4
   } state_t;

   state_t          state_reg, state_next;
   logic            active_reg, active_next;
   logic [7:0]      key_p0_reg, key_p0_next;
   logic [7:0]      key_p1_reg, key_p1_next;
   logic [9:0]      timer_reg, timer_next;
   logic [7:0]      turn_reg, turn_next;
   logic [FW-1:0]   flight_reg, flight_next;

   logic            own_bomb;
   logic [9:0]      timer_dec;

   // Register bank; low reset forces everything back to the idle game state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         active_reg <= 1'b0;
         key_p0_reg <= 8'h00;
         key_p1_reg <= 8'h00;
         timer_reg  <= 10'd0;
         turn_reg   <= 8'd0;
         flight_reg <= '0;
      end else begin
         state_reg  <= state_next;
         active_reg <= active_next;
         key_p0_reg <= key_p0_next;
         key_p1_reg <= key_p1_next;
         timer_reg  <= timer_next;
         turn_reg   <= turn_next;
         flight_reg <= flight_next;
      end
   end

   // Next-state, key gating, timer and counter updates for the turn sequence.
   always_comb begin
      state_next  = state_reg;
      active_next = active_reg;
      key_p0_next = 8'h00;
      key_p1_next = 8'h00;
      timer_next  = timer_reg;
      turn_next   = turn_reg;
      flight_next = flight_reg;

      // Only the current player's bomb matters; the other bit is ignored.
      own_bomb  = bomb_active[active_reg];
      // Frame-paced countdown that can never wrap below zero.
      timer_dec = (frame_tick && (timer_reg != 10'd0)) ? (timer_reg - 10'd1) : timer_reg;

      case (state_reg)
         IDLE: begin
            if (keycode == START_KEY) begin
               state_next  = AIM;
               active_next = 1'b0;
               timer_next  = 10'(TURN_FRAMES);
            end
         end

         AIM: begin
            // Keys reach only the player on turn, one clock late.
            if (active_reg)
               key_p1_next = keycode;
            else
               key_p0_next = keycode;
            timer_next = timer_dec;
            // A launch beats a simultaneous aim-window expiry.
            if (own_bomb) begin
               state_next  = FLIGHT;
               timer_next  = 10'd0;
               flight_next = '0;
            end else if (frame_tick && (timer_reg == 10'd1)) begin
               state_next = SWITCH;
            end
         end

         FLIGHT: begin
            if (frame_tick)
               flight_next = flight_reg + 1'b1;
            // Leave when the bomb resolves, or force an exit if it never does.
            if (!own_bomb ||
                (frame_tick && (flight_reg == FW'(FLIGHT_TIMEOUT - 1)))) begin
               state_next = SETTLE;
               timer_next = 10'(SETTLE_FRAMES);
            end
         end

         SETTLE: begin
            timer_next = timer_dec;
            if (frame_tick && (timer_reg <= 10'd1)) begin
               state_next = SWITCH;
               timer_next = 10'd0;
            end
         end

         SWITCH: begin
            active_next = ~active_reg;
            turn_next   = (turn_reg == 8'hFF) ? turn_reg : (turn_reg + 8'd1);
            timer_next  = 10'(TURN_FRAMES);
            state_next  = AIM;
         end

         default: begin
            state_next = IDLE;
            timer_next = 10'd0;
         end
      endcase
   end

   assign key_p0     = key_p0_reg;
   assign key_p1     = key_p1_reg;
   assign active     = active_reg;
   assign state      = state_reg;
   assign timer      = timer_reg;
   assign turn_count = turn_reg;

endmodule

// File: tb/tb_turn_scheduler.sv
// Testbench for turn_scheduler: directed turn scenarios, random play and a
// long saturation run, all compared cycle by cycle against a reference model.
module tb_turn_scheduler;

   localparam int         TF    = 4;
   localparam int         FT    = 8;
   localparam int         SF    = 6;
   localparam logic [7:0] START = 8'h28;

   localparam int S_IDLE = 0, S_AIM = 1, S_FLIGHT = 2, S_SETTLE = 3, S_SWITCH = 4;

   logic       clk;
   logic       reset;
   logic       frame_tick;
   logic [7:0] keycode;
   logic [1:0] bomb_active;
   logic [7:0] key_p0, key_p1;
   logic       active;
   logic [2:0] state;
   logic [9:0] timer;
   logic [7:0] turn_count;

   int total = 0;
   int bad   = 0;

   // Reference model: game phase plus the counters the rules talk about.
   int m_state, m_active, m_key0, m_key1, m_timer, m_turns, m_flight;

   turn_scheduler #(
      .TURN_FRAMES(TF), .FLIGHT_TIMEOUT(FT), .SETTLE_FRAMES(SF), .START_KEY(START)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .keycode(keycode),
      .bomb_active(bomb_active), .key_p0(key_p0), .key_p1(key_p1), .active(active),
      .state(state), .timer(timer), .turn_count(turn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_active = 0; m_key0 = 0; m_key1 = 0;
      m_timer = 0; m_turns = 0; m_flight = 0;
   endtask

   // One clock of the game rules, applied to the inputs seen at that edge.
   task automatic model_step(input logic [7:0] kc, input logic ft, input logic [1:0] ba);
      int mine;
      mine = ba[m_active];
      m_key0 = 0;
      m_key1 = 0;
      if (m_state == S_AIM) begin
         if (m_active == 1) m_key1 = kc; else m_key0 = kc;
      end
      case (m_state)
         S_IDLE: if (kc == START) begin
            m_state = S_AIM; m_active = 0; m_timer = TF;
         end
         S_AIM: begin
            if (ft) m_timer = m_timer - 1;
            if (mine == 1) begin
               m_state = S_FLIGHT; m_timer = 0; m_flight = 0;
            end else if (ft && m_timer == 0) begin
               m_state = S_SWITCH;
            end
         end
         S_FLIGHT: begin
            if (ft) m_flight = m_flight + 1;
            if (mine == 0 || m_flight == FT) begin
               m_state = S_SETTLE; m_timer = SF;
            end
         end
         S_SETTLE: if (ft) begin
            m_timer = m_timer - 1;
            if (m_timer == 0) m_state = S_SWITCH;
         end
         default: begin
            m_active = 1 - m_active;
            if (m_turns < 255) m_turns = m_turns + 1;
            m_timer = TF;
            m_state = S_AIM;
         end
      endcase
   endtask

   task automatic check_all();
      chk("state", state, m_state);
      chk("active", active, m_active);
      chk("key_p0", key_p0, m_key0);
      chk("key_p1", key_p1, m_key1);
      chk("timer", timer, m_timer);
      chk("turn_count", turn_count, m_turns);
   endtask

   task automatic step(input logic [7:0] kc, input logic ft, input logic [1:0] ba);
      keycode     = kc;
      frame_tick  = ft;
      bomb_active = ba;
      @(posedge clk);
      model_step(kc, ft, ba);
      #1;
      check_all();
   endtask

   initial begin
      int hold;
      int lvl;
      int swaps;
      int cyc;
      logic [1:0] ba;
      logic [7:0] kc;

      reset = 1'b0; frame_tick = 1'b0; keycode = 8'h00; bomb_active = 2'b00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("reset_state", state, S_IDLE);
      reset = 1'b1;

      // Start the game and route a key to player 0.
      step(START, 1'b0, 2'b00);
      chk("start_state", state, S_AIM);
      chk("start_timer", timer, TF);
      chk("start_key_p1", key_p1, 0);
      step(8'h04, 1'b0, 2'b00);
      chk("first_key_p0", key_p0, 8'h04);

      // Aim window expiry with no launch hands the turn to player 1.
      for (int i = 0; i < TF; i++) step(8'h05, 1'b1, 2'b00);
      chk("expire_switch", state, S_SWITCH);
      step(8'h00, 1'b0, 2'b00);
      chk("expire_active", active, 1);
      chk("expire_turns", turn_count, 1);
      chk("expire_timer", timer, TF);
      step(8'h09, 1'b0, 2'b00);
      chk("p1_keys", key_p1, 8'h09);
      chk("p0_blocked", key_p0, 0);

      // Normal turn for player 1: launch, resolve, settle, switch.
      step(8'h07, 1'b0, 2'b10);
      chk("launch_state", state, S_FLIGHT);
      step(8'h07, 1'b0, 2'b10);
      chk("flight_keys_blocked", key_p1, 0);
      step(8'h07, 1'b0, 2'b00);
      chk("settle_state", state, S_SETTLE);
      chk("settle_timer", timer, SF);
      for (int i = 0; i < SF; i++) step(8'h00, 1'b1, 2'b00);
      chk("settle_switch", state, S_SWITCH);
      step(8'h00, 1'b0, 2'b00);
      chk("turn2_active", active, 0);

      // Flight timeout for player 0 while the other bomb bit toggles.
      step(8'h00, 1'b0, 2'b01);
      for (int i = 1; i <= FT; i++) begin
         step(8'h00, 1'b1, {1'($urandom_range(0, 1)), 1'b1});
         if (i < FT) chk("flight_hold", state, S_FLIGHT);
         else        chk("flight_exit", state, S_SETTLE);
      end
      for (int i = 0; i < SF; i++) step(8'h00, 1'b1, 2'b01);
      step(8'h00, 1'b0, 2'b01);
      chk("turn3_active", active, 1);

      // Launch on the very frame the aim window would expire.
      for (int i = 0; i < TF - 1; i++) step(8'h00, 1'b1, 2'b00);
      chk("pre_expiry_timer", timer, 1);
      step(8'h00, 1'b1, 2'b10);
      chk("launch_wins_state", state, S_FLIGHT);
      chk("launch_wins_turns", turn_count, 3);

      // Asynchronous reset in mid-flight, sampled without a clock edge.
      step(8'h00, 1'b0, 2'b10);
      #1;
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;

      // Random play.
      hold = 0;
      lvl  = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            lvl  = $urandom_range(0, 1);
            hold = $urandom_range(1, 20);
         end
         hold--;
         ba = 2'($urandom_range(0, 3));
         ba[m_active] = lvl[0];
         kc = ($urandom_range(0, 3) == 0) ? START : 8'($urandom_range(0, 255));
         step(kc, ($urandom_range(0, 2) == 0), ba);
      end

      // Saturation: 260 quick turns from a fresh start.
      reset = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      swaps = 0;
      cyc   = 0;
      while (swaps < 260 && cyc < 20000) begin
         ba = 2'b00;
         if (m_state == S_AIM) ba[m_active] = 1'b1;
         step(START, 1'b1, ba);
         if (m_state == S_SWITCH) swaps++;
         cyc++;
      end
      chk("sat_turn_runs", swaps, 260);
      step(8'h00, 1'b1, 2'b00);
      chk("sat_turn_count", turn_count, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Two-player turn arbiter for the artillery game. It shares the single PS/2 keyboard and the per-player bomb launch between player 0 and player 1. Each turn runs in sequence: aim/move window, bomb flight, settle delay, hand-over. It sits between the keyboard interface and the two player instances: it gates `keycode` so that only the active player receives keys, and it watches that player's bomb-active flag to sequence the turn.

## Interface
Parameters:
- `TURN_FRAMES`, 600: frames allowed in the aim window (10 s at 60 Hz).
- `FLIGHT_TIMEOUT`, 480: maximum frames in FLIGHT before a forced exit.
- `SETTLE_FRAMES`, 60: frames of dead time after the bomb resolves.
- `START_KEY`, 8'h28: keycode that leaves IDLE (Enter).

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `frame_tick`, input, 1: one-`clk` pulse per video frame, synchronous to `clk`.
- `keycode`, input, 8: current key from the keyboard interface; 8'h00 means no key.
- `bomb_active`, input, 2: bit n is high while player n's bomb is in flight.
- `key_p0`, output, 8: gated keycode to player 0.
- `key_p1`, output, 8: gated keycode to player 1.
- `active`, output, 1: index of the player whose turn it is.
- `state`, output, 3: IDLE=0, AIM=1, FLIGHT=2, SETTLE=3, SWITCH=4.
- `timer`, output, 10: frames remaining in the current AIM or SETTLE window; 0 in other states.
- `turn_count`, output, 8: number of completed turns, saturating.

## Operation
- Reset values: `state`=IDLE, `active`=0, `key_p0`=`key_p1`=8'h00, `timer`=0, `turn_count`=0, internal flight counter=0.
- IDLE: both key outputs are 0.
  - On a `clk` edge with `keycode`==`START_KEY`: go to AIM, `active`=0, `timer`=`TURN_FRAMES`.
- AIM:
  - Key outputs are registered: `key_p[active]` <= `keycode`, the other output <= 0.
  - On each `frame_tick`, `timer` decrements by 1.
  - If `bomb_active[active]`==1: go to FLIGHT and clear the flight counter.
  - Else if `frame_tick` arrives with `timer`==1 (expiry): go to SWITCH. No launch occurs in this case.
  - If launch and expiry happen in the same cycle, FLIGHT wins.
- FLIGHT:
  - Both key outputs are 0, which blocks movement and re-aim.
  - The flight counter increments on each `frame_tick`.
  - If `bomb_active[active]`==0, or `frame_tick` arrives with the counter at `FLIGHT_TIMEOUT`-1: go to SETTLE, `timer`=`SETTLE_FRAMES`.
- SETTLE: both key outputs are 0; `timer` decrements on `frame_tick`; go to SWITCH when it reaches 0 on a `frame_tick`.
- SWITCH: lasts exactly one `clk`.
  - `active` <= ~`active`.
  - `turn_count` <= `turn_count`+1, saturating at 255.
  - `timer` <= `TURN_FRAMES`; go to AIM.
- The `bomb_active` bit of the non-active player is ignored in all states.
- `timer` never underflows. It stays at 0 outside AIM and SETTLE, and is set to 0 on entering FLIGHT.
- Reset asserted mid-turn (any state) returns every register to its reset value immediately. The game restarts from IDLE.

## Timing
- Key gating latency is 1 `clk`: a `keycode` change at edge k appears on `key_p*` after edge k+1.
- State transitions take effect on the `clk` edge that samples the condition. Outputs are registered, with no combinational path from inputs.
- Gating changes one cycle after the state changes:
  - Entering FLIGHT, SETTLE or SWITCH: the active output goes to 0 one cycle later.
  - Entering AIM: the new player's keys pass one cycle after entry.
- Timer and counters change only on cycles with `frame_tick`=1. The exception is loads on state entry, which occur on `clk` regardless of `frame_tick`.
- Aim-window length: exactly `TURN_FRAMES` frame_ticks from AIM entry to SWITCH.
- Minimum turn with an immediate launch and immediate resolution: 1 (AIM) + 1 (FLIGHT) + `SETTLE_FRAMES` frame_ticks + 1 `clk` (SWITCH).
- `bomb_active` is assumed synchronous to `clk`; no synchronizer is inside this block.

## Test plan
- Reset and start: hold `reset`=0, release, apply `keycode`=8'h28 for 1 cycle.
  - Required: `state`=1, `active`=0, `timer`=600, `key_p1`=0.
  - Applying `keycode`=8'h04 then gives `key_p0`=8'h04 one cycle later.
- Aim timeout, with `TURN_FRAMES`=4 and no launch: after 4 frame_ticks, `state` passes through 4 to 1.
  - Required: `active`=1, `turn_count`=1, `timer`=4.
  - `keycode` now appears only on `key_p1`.
- Normal turn:
  - In AIM, raise `bomb_active[0]`: `state`=2 and `key_p0` is forced to 0 even with `keycode`=8'h07.
  - Drop `bomb_active[0]`: `state`=3, `timer`=60.
  - After 60 frame_ticks: SWITCH, then AIM with `active`=1.
- Flight timeout, with `FLIGHT_TIMEOUT`=8: hold `bomb_active[0]`=1 indefinitely.
  - Required: SETTLE is entered on the 8th frame_tick after FLIGHT entry.
  - `bomb_active[1]` toggling has no effect.
- Simultaneous launch and expiry: set `timer`=1, then assert `frame_tick` and `bomb_active[active]` in the same cycle.
  - Required: `state`=2 and `turn_count` is unchanged.
- Reset mid-FLIGHT and saturation:
  - Pulse `reset` low in FLIGHT: all outputs go to reset values asynchronously.
  - Separately, run 260 turns: `turn_count` holds at 255.
